// File: rtl/cpu.sv
// cpu -- 16-bit LC-3-subset processor core with an SRAM-style memory port.
//
// Fetches instructions over an asynchronous SRAM interface (handshaked by
// mem_ready), executes ADD/AND/NOT/BR/JMP/LD/ST/LDR/STR and optionally PAUSE.
// Any other opcode is a NOP.
//
// Optional feature macro: CPU_PAUSE_EN
//   defined   : opcode 1101 parks the core in PAUSE until Continue is seen
//               low and then high.
//   undefined : opcode 1101 is a NOP, Continue is ignored, no PAUSE state.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      asynchronous active-low reset
//   Run        high: run from HALT; low: halt after the current instruction
//   Continue   releases PAUSE (0 then 1)
//   mem_ready  access complete, sampled every cycle of an access
//   Data_in    memory read data
//   Data_out   memory write data (always MDR)
//   A          memory address {4'b0, MAR}
//   CE,UB,LB,OE,WE  active-low memory controls, registered
module cpu #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Run,
   input  logic        Continue,
   input  logic        mem_ready,
   input  logic [15:0] Data_in,
   output logic [15:0] Data_out,
   output logic [19:0] A,
   output logic        CE,
   output logic        UB,
   output logic        LB,
   output logic        OE,
   output logic        WE
);

   typedef enum logic [3:0] {
      S_HALT, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_EXEC,
      S_LDADR, S_MEMRD, S_LDWB, S_STADR, S_MEMWR, S_STDONE
`ifdef CPU_PAUSE_EN
      , S_PAUSE
`endif
   } state_t;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_JMP = 4'b1100;
`ifdef CPU_PAUSE_EN
   localparam logic [3:0] OP_PSE = 4'b1101;
`endif

   // control word order: {CE, UB, LB, OE, WE}
   localparam logic [4:0] CTL_IDLE  = 5'b11111;
   localparam logic [4:0] CTL_READ  = 5'b00001;
   localparam logic [4:0] CTL_WRITE = 5'b00010;

   state_t            state, state_n;
   logic [15:0]       pc, ir, mar, mdr;
   logic [7:0][15:0]  regs;
   logic [2:0]        nzp;
   logic [4:0]        ctl, ctl_n;

   logic [3:0]  opcode;
   logic [2:0]  dr, sr1, sr2;
   logic [15:0] off9, off6, imm5, src_a, src_b, alu_res, mem_addr;
   state_t      done_state;

   function automatic logic [2:0] nzp_of(input logic [15:0] v);
      if (v[15])          return 3'b100;
      else if (v == '0)   return 3'b010;
      else                return 3'b001;
   endfunction

   assign opcode = ir[15:12];
   assign dr     = ir[11:9];
   assign sr1    = ir[8:6];
   assign sr2    = ir[2:0];
   assign off9   = {{7{ir[8]}}, ir[8:0]};
   assign off6   = {{10{ir[5]}}, ir[5:0]};
   assign imm5   = {{11{ir[4]}}, ir[4:0]};
   assign src_a  = regs[sr1];
   assign src_b  = ir[5] ? imm5 : regs[sr2];

   always_comb begin
      alu_res = ~src_a;
      case (opcode)
         OP_ADD:  alu_res = src_a + src_b;
         OP_AND:  alu_res = src_a & src_b;
         default: alu_res = ~src_a;
      endcase
   end

   // PC-relative for LD/ST, base+offset for LDR/STR; pc is already incremented
   assign mem_addr   = (opcode == OP_LD || opcode == OP_ST) ? pc + off9 : src_a + off6;
   assign done_state = Run ? S_FETCH1 : S_HALT;

   assign Data_out = mdr;
   assign A        = {4'b0000, mar};
   assign {CE, UB, LB, OE, WE} = ctl;

`ifdef CPU_PAUSE_EN
   logic cont_low;  // Continue has been seen low since entering PAUSE
`else
   logic unused_continue;
   assign unused_continue = Continue;
`endif

   // ---------------- next state ----------------
   always_comb begin
      state_n = state;
      case (state)
         S_HALT:   if (Run) state_n = S_FETCH1;
         S_FETCH1: state_n = S_FETCH2;
         S_FETCH2: if (mem_ready) state_n = S_FETCH3;
         S_FETCH3: state_n = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LD, OP_LDR: state_n = S_LDADR;
               OP_ST, OP_STR: state_n = S_STADR;
`ifdef CPU_PAUSE_EN
               OP_PSE:        state_n = S_PAUSE;
`endif
               default:       state_n = S_EXEC;
            endcase
         end
         S_EXEC:   state_n = done_state;
         S_LDADR:  state_n = S_MEMRD;
         S_MEMRD:  if (mem_ready) state_n = S_LDWB;
         S_LDWB:   state_n = done_state;
         S_STADR:  state_n = S_MEMWR;
         S_MEMWR:  if (mem_ready) state_n = S_STDONE;
         S_STDONE: state_n = done_state;
`ifdef CPU_PAUSE_EN
         S_PAUSE:  if (cont_low && Continue) state_n = done_state;
`endif
         default:  state_n = S_HALT;
      endcase
   end

   // Controls are derived from the next state and registered, so they are
   // glitch-free and stable for the whole access.
   always_comb begin
      ctl_n = CTL_IDLE;
      case (state_n)
         S_FETCH2, S_MEMRD: ctl_n = CTL_READ;
         S_MEMWR:           ctl_n = CTL_WRITE;
         default:           ctl_n = CTL_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= S_HALT;
         ctl   <= CTL_IDLE;
      end else begin
         state <= state_n;
         ctl   <= ctl_n;
      end
   end

`ifdef CPU_PAUSE_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         cont_low <= 1'b0;
      else if (state != S_PAUSE)
         cont_low <= 1'b0;
      else if (!Continue)
         cont_low <= 1'b1;
   end
`endif

   // ---------------- datapath ----------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc   <= RESET_PC;
         ir   <= '0;
         mar  <= '0;
         mdr  <= '0;
         regs <= '0;
         nzp  <= 3'b010;
      end else begin
         case (state)
            S_FETCH1: begin
               mar <= pc;
               pc  <= pc + 16'd1;
            end
            S_FETCH2, S_MEMRD: if (mem_ready) mdr <= Data_in;
            S_FETCH3: ir <= mdr;
            S_EXEC: begin
               case (opcode)
                  OP_ADD, OP_AND, OP_NOT: begin
                     regs[dr] <= alu_res;
                     nzp      <= nzp_of(alu_res);
                  end
                  OP_BR:  if ((dr & nzp) != 3'b000) pc <= pc + off9;
                  OP_JMP: pc <= src_a;
                  default: ;
               endcase
            end
            S_LDADR: mar <= mem_addr;
            S_LDWB: begin
               regs[dr] <= mdr;
               nzp      <= nzp_of(mdr);
            end
            S_STADR: begin
               mar <= mem_addr;
               mdr <= regs[dr];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: a small program in a behavioural SRAM exercises
// loads, stores, ALU ops, branches, JMP, a fetch stall, halt on Run low,
// PAUSE (when CPU_PAUSE_EN is defined) and reset in the middle of an access.
module tb_cpu;
   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        Run = 1'b0;
   logic        Continue = 1'b1;
   logic        mem_ready = 1'b1;
   logic [15:0] Data_in, Data_out;
   logic [19:0] A;
   logic        CE, UB, LB, OE, WE;

   logic [15:0] mem [0:255];
   assign Data_in = mem[A[7:0]];

   cpu #(.RESET_PC(16'h0000)) dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
      .mem_ready(mem_ready), .Data_in(Data_in), .Data_out(Data_out),
      .A(A), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // access log: one entry per completed access
   logic [19:0] la [0:127];
   logic [15:0] ldat [0:127];
   logic [4:0]  lc [0:127];
   int          lt [0:127];
   int          acc_n = 0;

   always @(negedge Clk) begin
      if (Reset && !CE && mem_ready) begin
         if (acc_n < 128) begin
            la[acc_n]   <= A;
            ldat[acc_n] <= WE ? Data_in : Data_out;
            lc[acc_n]   <= {CE, UB, LB, OE, WE};
            lt[acc_n]   <= cyc;
         end
         acc_n <= acc_n + 1;
         if (!WE) mem[A[7:0]] <= Data_out;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic wait_acc(input int n);
      int k = 0;
      while (acc_n < n && k < 3000) begin
         @(posedge Clk); #1;
         k++;
      end
      chk("wait_acc", 32'(acc_n >= n), 32'd1);
   endtask

   initial begin
      int n0;
      int k;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h00] = 16'h2C07; // LD  R6,#7      -> M[8]
      mem[8'h01] = 16'h2A1E; // LD  R5,#30     -> M[0x20]
      mem[8'h02] = 16'h3A06; // ST  R5,#6      -> M[9]
      mem[8'h03] = 16'h0806; // BRn +6         -> 0x0A
      mem[8'h08] = 16'h1234;
      mem[8'h0A] = 16'h1261; // ADD R1,R1,#1
      mem[8'h0B] = 16'h127F; // ADD R1,R1,#-1
      mem[8'h0C] = 16'h05FE; // BRz -2
      mem[8'h0D] = 16'h3213; // ST  R1        -> M[0x21]
      mem[8'h0E] = 16'h2413; // LD  R2        <- M[0x22]
      mem[8'h0F] = 16'h14A1; // ADD R2,R2,#1
      mem[8'h10] = 16'h0801; // BRn +1
      mem[8'h11] = 16'h341D; // ST  R2        -> M[0x2F] (skipped)
      mem[8'h12] = 16'h3410; // ST  R2        -> M[0x23]
      mem[8'h13] = 16'h96BF; // NOT R3,R2
      mem[8'h14] = 16'h58C6; // AND R4,R3,R6
      mem[8'h15] = 16'h592F; // AND R4,R4,#15
      mem[8'h16] = 16'h2E0D; // LD  R7        <- M[0x24]
      mem[8'h17] = 16'h79C2; // STR R4,R7,#2
      mem[8'h18] = 16'h61C1; // LDR R0,R7,#1
      mem[8'h19] = 16'h1004; // ADD R0,R0,R4
      mem[8'h1A] = 16'h71C3; // STR R0,R7,#3
      mem[8'h1B] = 16'h8000; // unsupported -> NOP
      mem[8'h1C] = 16'hD000; // PAUSE / NOP
      mem[8'h1D] = 16'h3616; // ST  R3        -> M[0x34]
      mem[8'h1E] = 16'hC1C0; // JMP R7
      mem[8'h20] = 16'hBEEF;
      mem[8'h22] = 16'h7FFF;
      mem[8'h24] = 16'h0040;
      mem[8'h40] = 16'h0FFF; // BRnzp -1 (spin)
      mem[8'h41] = 16'h5A5A;

      // reset state
      #12;
      chk("rst_ctl", 32'({CE, UB, LB, OE, WE}), 32'h1F);
      chk("rst_A", 32'(A), 32'h0);
      chk("rst_dout", 32'(Data_out), 32'h0);
      @(posedge Clk); #1;
      Reset = 1'b1;
      repeat (10) @(posedge Clk);
      #1;
      chk("idle_no_access", 32'(acc_n), 32'd0);
      chk("idle_ctl", 32'({CE, UB, LB, OE, WE}), 32'h1F);

      // run; stall the first fetch of 0x0B for three cycles
      Run = 1'b1;
      k = 0;
      while (!(!CE && A == 20'h0000B) && k < 500) begin
         @(posedge Clk); #1;
         k++;
      end
      chk("stall_found", 32'(k < 500), 32'd1);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
         chk("stall_ctl", 32'({CE, UB, LB, OE, WE}), 32'h01);
         chk("stall_A", 32'(A), 32'h0B);
      end
      mem_ready = 1'b1;

      wait_acc(34);
`ifdef CPU_PAUSE_EN
      repeat (10) @(posedge Clk);
      #1;
      chk("pause_hold", 32'(acc_n), 32'd34);
      Continue = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk("pause_low", 32'(acc_n), 32'd34);
      Continue = 1'b1;
      wait_acc(35);
      chk("pause_next_A", 32'(la[34]), 32'h1D);
`else
      wait_acc(35);
      chk("d000_nop_cyc", 32'(lt[34] - lt[33]), 32'd5);
      chk("d000_nop_A", 32'(la[34]), 32'h1D);
`endif

      // halt after the current instruction once Run drops
      wait_acc(40);
      Run = 1'b0;
      repeat (20) @(posedge Clk);
      #1;
      n0 = acc_n;
      repeat (20) @(posedge Clk);
      #1;
      chk("halt_no_access", 32'(acc_n), 32'(n0));
      chk("halt_ctl", 32'({CE, UB, LB, OE, WE}), 32'h1F);

      // access log and memory results
      chk("ld_fetch_A", 32'(la[0]), 32'h0);
      chk("read_ctl", 32'(lc[0]), 32'h01);
      chk("ld_data_A", 32'(la[1]), 32'h8);
      chk("ld_data", 32'(ldat[1]), 32'h1234);
      chk("ld_cyc", 32'(lt[2] - lt[0]), 32'd7);
      chk("ld2_A", 32'(la[3]), 32'h20);
      chk("st_A", 32'(la[5]), 32'h9);
      chk("st_ctl", 32'(lc[5]), 32'h02);
      chk("st_data", 32'(ldat[5]), 32'hBEEF);
      chk("st_cyc", 32'(lt[6] - lt[4]), 32'd7);
      chk("brn_ld_nzp", 32'(la[7]), 32'h0A);
      chk("br_cyc", 32'(lt[7] - lt[6]), 32'd5);
      chk("stall_cyc", 32'(lt[8] - lt[7]), 32'd8);
      chk("post_stall_cyc", 32'(lt[9] - lt[8]), 32'd5);
      chk("brz_taken", 32'(la[10]), 32'h0B);
      chk("brz_not_taken", 32'(la[12]), 32'h0D);
      chk("brn_add_ovf", 32'(la[18]), 32'h12);
      chk("jmp_A", 32'(la[37]), 32'h40);
      chk("m21_add_wrap", 32'(mem[8'h21]), 32'hFFFF);
      chk("m2f_skipped", 32'(mem[8'h2F]), 32'h0000);
      chk("m23_7fff_p1", 32'(mem[8'h23]), 32'h8000);
      chk("m42_and", 32'(mem[8'h42]), 32'h0004);
      chk("m43_ldr_add", 32'(mem[8'h43]), 32'h5A5E);
      chk("m34_not", 32'(mem[8'h34]), 32'h7FFF);

      // reset in the middle of an access
      Run = 1'b1;
      k = 0;
      while (CE && k < 50) begin
         @(posedge Clk); #1;
         k++;
      end
      chk("rst_mid_found", 32'(k < 50), 32'd1);
      chk("pre_rst_A", 32'(A), 32'h40);
      Reset = 1'b0;
      #1;
      chk("rst_mid_ctl", 32'({CE, UB, LB, OE, WE}), 32'h1F);
      chk("rst_mid_A", 32'(A), 32'h0);
      chk("rst_mid_dout", 32'(Data_out), 32'h0);
      @(posedge Clk); #1;
      Reset = 1'b1;
      n0 = acc_n;
      wait_acc(n0 + 1);
      chk("restart_A", 32'(la[n0]), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
